// File: rtl/baud_rate_ctrl.sv
// Baud tick generator with a runtime divisor that changes only when tx/rx are idle on a tick boundary.
// Optional autobaud measurement is enabled by defining BAUD_AUTOBAUD_EN.
module baud_rate_ctrl #(
    parameter int N           = 16,
    parameter int DEFAULT_DIV = 651,
    parameter int MIN_DIV     = 16
) (
    input  logic         clk_100MHz,
    input  logic         reset,
    input  logic [N-1:0] cfg_div,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic         tx_busy,
    input  logic         rx_busy,
    output logic         tick,
    output logic [N-1:0] div_active,
    output logic         cfg_pending,
    output logic         cfg_err
`ifdef BAUD_AUTOBAUD_EN
    ,
    input  logic         rx_in,
    input  logic         autobaud_req
`endif
);

    localparam logic [N-1:0] DEF_N = N'(DEFAULT_DIV);
    localparam logic [N-1:0] MIN_N = N'(MIN_DIV);
    localparam logic [N-1:0] ONE_N = N'(1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PEND    = 2'd1,
        APPLY   = 2'd2
`ifdef BAUD_AUTOBAUD_EN
        ,
        MEASURE = 2'd3
`endif
    } state_t;

    state_t       state;
    logic [N-1:0] counter;
    logic [N-1:0] shadow;
    logic [N-1:0] cnt_nxt;
    logic [N-1:0] div_nxt;

`ifdef BAUD_AUTOBAUD_EN
    logic [N+3:0] meas_cnt;
    logic         meas_run;
    logic         rx_prev;
    logic [N-1:0] candidate;
    logic         meas_sat;

    assign candidate = meas_cnt[N+3:4];
    assign meas_sat  = &meas_cnt;
`endif

    // Next counter/divisor; APPLY restarts the phase at the new rate.
    always_comb begin
        cnt_nxt = counter + ONE_N;
        div_nxt = div_active;
        if (state == APPLY) begin
            cnt_nxt = '0;
            div_nxt = shadow;
        end else if (tick) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = counter + ONE_N;
        end
    end

    // Tick is registered as a look-ahead of counter == div_active-1.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            counter    <= '0;
            div_active <= DEF_N;
            tick       <= 1'b0;
        end else begin
            counter    <= cnt_nxt;
            div_active <= div_nxt;
            tick       <= (cnt_nxt == (div_nxt - ONE_N));
        end
    end

    // Request handshake and safe-point sequencing.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            shadow      <= DEF_N;
            cfg_ready   <= 1'b1;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
`ifdef BAUD_AUTOBAUD_EN
            meas_cnt    <= '0;
            meas_run    <= 1'b0;
            rx_prev     <= 1'b1;
`endif
        end else begin
            cfg_err <= 1'b0;
`ifdef BAUD_AUTOBAUD_EN
            rx_prev <= rx_in;
`endif
            case (state)
                RUN: begin
                    if (cfg_valid) begin
                        if (cfg_div < MIN_N) begin
                            cfg_err <= 1'b1;
                        end else begin
                            shadow      <= cfg_div;
                            state       <= PEND;
                            cfg_ready   <= 1'b0;
                            cfg_pending <= 1'b1;
                        end
                    end
`ifdef BAUD_AUTOBAUD_EN
                    else if (autobaud_req) begin
                        state     <= MEASURE;
                        cfg_ready <= 1'b0;
                        meas_run  <= 1'b0;
                        meas_cnt  <= '0;
                    end
`endif
                end
                PEND: begin
                    // The qualifying tick itself still belongs to the old rate.
                    if (tick && !tx_busy && !rx_busy) begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    state       <= RUN;
                    cfg_ready   <= 1'b1;
                    cfg_pending <= 1'b0;
                end
`ifdef BAUD_AUTOBAUD_EN
                MEASURE: begin
                    if (!meas_run) begin
                        if (rx_prev && !rx_in) begin
                            meas_run <= 1'b1;
                            meas_cnt <= (N+4)'(1);
                        end
                    end else if (!rx_in) begin
                        if (!meas_sat) begin
                            meas_cnt <= meas_cnt + (N+4)'(1);
                        end
                    end else if (meas_sat || (candidate < MIN_N)) begin
                        cfg_err   <= 1'b1;
                        state     <= RUN;
                        cfg_ready <= 1'b1;
                        meas_run  <= 1'b0;
                    end else begin
                        shadow      <= candidate;
                        state       <= PEND;
                        cfg_pending <= 1'b1;
                        meas_run    <= 1'b0;
                    end
                end
`endif
                default: begin
                    state       <= RUN;
                    cfg_ready   <= 1'b1;
                    cfg_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
